// File: rtl/dram_async_edgelogic_flt.sv
// Hold-qualified driver for DRAM async pads: each channel registers a new pad level,
// then ignores further requests until that level has been on the pad for MIN_HOLD cycles.
module dram_async_edgelogic_flt #(
  parameter int                WIDTH    = 4,
  parameter int                MIN_HOLD = 3,
  parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [WIDTH-1:0] data,
  input  logic             bypass,
  output logic [WIDTH-1:0] to_pad,
  output logic [WIDTH-1:0] hold_busy
);

  localparam int             CNT_W    = $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit             USE_HOLD = (MIN_HOLD > 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [WIDTH-1:0] q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             q_bit;
    logic             busy;

    always_ff @(posedge clk) begin
      if (!rst_l) begin
        q_bit <= RST_VAL[gi];
        cnt   <= '0;
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (data[gi] != q_bit) begin
              q_bit <= data[gi];
              cnt   <= CNT_LOAD;
              state <= USE_HOLD ? HOLD : IDLE;
              busy  <= USE_HOLD;
            end
          end
          HOLD: begin
            // Requests are ignored here; the counter saturates at zero on the exit edge.
            cnt <= (cnt != '0) ? cnt - CNT_ONE : '0;
            if (cnt <= CNT_ONE) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign q[gi]         = q_bit;
    assign hold_busy[gi] = busy;
  end

  // Bypass is a pure output mux so it stays transparent even while reset is held.
  assign to_pad = bypass ? data : q;

endmodule

// File: doc/dram_async_edgelogic_flt.md
DRAM_ASYNC_EDGELOGIC_FLT -- requirements
Module: dram_async_edgelogic_flt

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the number of independent async pad channels (range 1..32).
REQ-002 The module SHALL have parameter MIN_HOLD, default 3, giving the minimum cycles a new pad value is held (range 1..255).
REQ-003 The module SHALL have parameter RST_VAL, WIDTH bits, default all-zero, giving the reset value of the pad register.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_l, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port data, input, WIDTH bits: requested pad level per channel, from core logic.
REQ-007 The module SHALL have port bypass, input, 1 bit, quasi-static: 1 makes to_pad follow data combinationally.
REQ-008 The module SHALL have port to_pad, output, WIDTH bits: level driven to the DRAM async pads.
REQ-009 The module SHALL have port hold_busy, output, WIDTH bits: registered, 1 while a channel is in HOLD.

Function
REQ-010 Each channel i SHALL contain a pad register q[i], a hold counter cnt[i] of clog2(MIN_HOLD+1) bits, and a two-state FSM {IDLE, HOLD}.
REQ-011 In IDLE, when data[i] != q[i] at a clock edge, that edge SHALL load q[i] <= data[i] and cnt[i] <= MIN_HOLD-1.
REQ-012 On that same edge the FSM SHALL go to HOLD if MIN_HOLD > 1, else stay in IDLE.
REQ-013 In IDLE, when data[i] == q[i], q[i], cnt[i] and the state SHALL be unchanged.
REQ-014 In HOLD, data[i] SHALL be ignored and cnt[i] SHALL decrement by 1 each edge.
REQ-015 In HOLD, the edge on which cnt[i] goes from 1 to 0 SHALL return the FSM to IDLE.
REQ-016 A new q[i] value SHALL therefore remain for exactly MIN_HOLD cycles minimum; the earliest next update is MIN_HOLD edges after the previous update.
REQ-017 Latency from a data[i] change to to_pad[i] SHALL be 1 cycle when the channel is IDLE and bypass=0.
REQ-018 A data[i] pulse that starts and ends inside a HOLD window SHALL be dropped; at IDLE re-entry only the current data[i] is compared.
REQ-019 If data[i] differs from q[i] on the edge where HOLD exits, the update SHALL occur on the following edge (the first IDLE edge).
REQ-020 hold_busy[i] SHALL equal 1 exactly when the channel FSM is in HOLD.
REQ-021 to_pad SHALL equal data when bypass=1 and q when bypass=0; the mux is combinational and per-bit identical.
REQ-022 q, cnt and the FSMs SHALL keep operating normally while bypass=1, so that deasserting bypass presents an up-to-date, hold-qualified q.
REQ-023 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each update on the same edge.
REQ-024 cnt[i] SHALL never underflow or wrap; in IDLE it SHALL hold 0.

Reset
REQ-025 On any clock edge with rst_l=0, every channel SHALL set q=RST_VAL, cnt=0 and state=IDLE, and hold_busy SHALL be all-zero, overriding all other activity.
REQ-026 Reset asserted mid-HOLD SHALL abort the hold immediately on that edge; after rst_l returns to 1, the first edge with data != RST_VAL SHALL update q.
REQ-027 Reset SHALL not gate the bypass mux; with bypass=1, to_pad SHALL follow data even during reset.

Verification
REQ-028 WIDTH=4, MIN_HOLD=3, RST_VAL=0: reset, then set data=4'b0001 at edge k -> to_pad=0001 after edge k; hold_busy[0]=1 for edges k..k+1; hold_busy[0]=0 after edge k+2.
REQ-029 After REQ-028, drive data[0]=0 at edge k+1 and back to 1 at edge k+2 -> pulse dropped; to_pad[0] stays 1; no update at edge k+3.
REQ-030 Set data[0]=0 at edge k+1 and hold it -> to_pad[0] stays 1 through edge k+2 and falls to 0 at edge k+3.
REQ-031 Drive data=4'b1111 from 0000 on one edge -> all bits update together; hold_busy=1111 for 2 cycles.
REQ-032 Assert rst_l=0 mid-HOLD -> next edge gives to_pad=RST_VAL and hold_busy=0; with bypass=1, to_pad=data immediately, and on release of bypass to_pad=q.
REQ-033 MIN_HOLD=1: toggle data every cycle -> to_pad follows with 1-cycle latency, and hold_busy stays 0.
